// File: rtl/wb_regfile.sv
// Writeback stage: selects load data or ALU result, commits it to a 32x32 register
// file with two async read ports, and counts committed writes. Macro: REGFILE_BYPASS_EN.
module wb_regfile #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    readMem_i,
  input  logic [XLEN-1:0]    ALUresult_i,
  input  logic [4:0]         wr_i,
  input  logic               mem_wb_RegWrite_i,
  input  logic               mem_wb_MemToReg_i,
  input  logic [4:0]         rs1_i,
  input  logic [4:0]         rs2_i,
  output logic [XLEN-1:0]    rdata1_o,
  output logic [XLEN-1:0]    rdata2_o,
  output logic [XLEN-1:0]    wb_data_o,
  output logic [COUNT_W-1:0] wr_count_o
);

  logic [XLEN-1:0]    regs_q [NREGS];
  logic [COUNT_W-1:0] wr_count_q, wr_count_d;
  logic [XLEN-1:0]    wb_data;
  logic               commit;

  assign wb_data   = mem_wb_MemToReg_i ? readMem_i : ALUresult_i;
  assign commit    = mem_wb_RegWrite_i && (wr_i != 5'd0);
  assign wb_data_o = wb_data;

  always_comb begin
    wr_count_d = wr_count_q;
    if (commit) wr_count_d = wr_count_q + COUNT_W'(1);
  end

  // Writeback edge: reset wins over a same-cycle commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      wr_count_q <= '0;
    end else begin
      if (commit) regs_q[wr_i] <= wb_data;
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count_o = wr_count_q;

  // commit already excludes x0, so the bypass can never forward into x0.
  always_comb begin
    rdata1_o = regs_q[rs1_i];
`ifdef REGFILE_BYPASS_EN
    if (commit && (rs1_i == wr_i)) rdata1_o = wb_data;
`endif
    if (rs1_i == 5'd0) rdata1_o = '0;
  end

  always_comb begin
    rdata2_o = regs_q[rs2_i];
`ifdef REGFILE_BYPASS_EN
    if (commit && (rs2_i == wr_i)) rdata2_o = wb_data;
`endif
    if (rs2_i == 5'd0) rdata2_o = '0;
  end

endmodule
